// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising CPU-RAM controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnMem
  } owner_e;

  localparam logic [1:0] LenB = 2'b00;
  localparam logic [1:0] LenH = 2'b01;
  localparam logic [1:0] LenW = 2'b10;

  // Length code 2'b11 is served as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenB:    return 3'd1;
      LenH:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester (IF, MEM) and byte-wide RAM signals of mem_ctrl.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_done;
  logic [31:0]           if_rdata;

  logic                  mem_req;
  logic                  mem_wr;
  logic [1:0]            mem_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_done;
  logic [31:0]           mem_rdata;

  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_rdata, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_rdata, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port, serialising
// each request into byte accesses and assembling little-endian read data.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus,
  output logic      busy
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  busy_q, busy_d;

  logic [2:0]            cnt_inc;
  logic [1:0]            cap_idx;
  logic [1:0]            wr_idx;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    ram_a_d     = '0;
    ram_wr_d    = 1'b0;
    ram_dout_d  = '0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_inc     = cnt_q + 3'd1;
    // RAM data lags the address by one cycle, so the byte landing now is for cnt_q-1.
    cap_idx     = 2'(cnt_q - 3'd1);
    wr_idx      = 2'(cnt_inc);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.mem_req) begin
          owner_d  = OwnMem;
          addr_d   = bus.mem_addr;
          nbytes_d = len_bytes(bus.mem_len);
          wdata_d  = bus.mem_wdata;
          ram_a_d  = bus.mem_addr;
          if (bus.mem_wr) begin
            state_d    = StWrite;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata[7:0];
          end else begin
            state_d     = StRead;
            mem_rdata_d = '0;
          end
        end else if (bus.if_req) begin
          owner_d    = OwnIf;
          addr_d     = bus.if_addr;
          nbytes_d   = 3'd4;
          ram_a_d    = bus.if_addr;
          state_d    = StRead;
          if_rdata_d = '0;
        end
      end

      StRead: begin
        if (owner_q == OwnIf && bus.if_flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q != 3'd0) begin
            if (owner_q == OwnIf) if_rdata_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
            else                  mem_rdata_d[{cap_idx, 3'b000} +: 8] = bus.ram_din;
          end
          if (cnt_inc < nbytes_q) ram_a_d = addr_q + ADDR_WIDTH'(cnt_inc);
          if (cnt_q == nbytes_q) begin
            state_d = StDone;
            if (owner_q == OwnIf) if_done_d = 1'b1;
            else                  mem_done_d = 1'b1;
          end
        end
      end

      StWrite: begin
        cnt_d = cnt_inc;
        if (cnt_inc < nbytes_q) begin
          ram_a_d    = addr_q + ADDR_WIDTH'(cnt_inc);
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
        end else begin
          state_d    = StDone;
          mem_done_d = 1'b1;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      addr_q      <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level model and a reference byte memory.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  logic busy;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency; backdoor port used for preloading.
  logic [7:0] ram [1024];
  logic [7:0] ram_din_r;
  logic       bd_we;
  logic [9:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    ram_din_r <= ram[bus.ram_a[9:0]];
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.ram_wr) ram[bus.ram_a[9:0]] <= bus.ram_dout;
  end
  assign bus.ram_din = ram_din_r;

  logic [7:0]  ref_mem [1024];
  logic [31:0] last_if_rdata;
  logic [31:0] last_mem_rdata;
  int          checks;
  int          failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int len2n(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic int ridx(input logic [31:0] a);
    return int'(a[9:0]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_mem[ridx(addr + 32'(i))];
    return w;
  endfunction

  task automatic bd_write(input int a, input logic [7:0] d);
    bd_addr = 10'(a);
    bd_data = d;
    bd_we   = 1'b1;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One transaction from an idle controller; every cycle's RAM-side and handshake
  // outputs are compared with what the byte-serial protocol requires.
  task automatic run_txn(input bit is_mem, input bit wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit rand_flush);
    int          n;
    int          last;
    logic [31:0] exp_rd;
    logic [31:0] exp_a;
    logic        exp_wr;
    logic [7:0]  exp_do;
    logic        exp_md;
    logic        exp_id;
    n      = is_mem ? len2n(len) : 4;
    last   = wr ? n + 1 : n + 2;
    exp_rd = '0;
    if (wr) for (int i = 0; i < n; i++) ref_mem[ridx(addr + 32'(i))] = wdata[8*i +: 8];
    else exp_rd = model_read(addr, n);

    step();
    if (is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_wr    = wr;
      bus.mem_len   = len;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end

    for (int k = 1; k <= last + 1; k++) begin
      step();
      exp_a  = '0;
      exp_wr = 1'b0;
      exp_do = '0;
      exp_md = 1'b0;
      exp_id = 1'b0;
      if (k <= n) begin
        exp_a = addr + 32'(k - 1);
        if (wr) begin
          exp_wr = 1'b1;
          exp_do = 8'(wdata >> (8 * (k - 1)));
        end
      end
      if (k == last) begin
        if (is_mem) exp_md = 1'b1;
        else        exp_id = 1'b1;
      end
      check_eq($sformatf("ram_a c%0d", k), bus.ram_a, exp_a);
      check_eq($sformatf("ram_wr c%0d", k), 32'(bus.ram_wr), 32'(exp_wr));
      check_eq($sformatf("ram_dout c%0d", k), 32'(bus.ram_dout), 32'(exp_do));
      check_eq($sformatf("mem_done c%0d", k), 32'(bus.mem_done), 32'(exp_md));
      check_eq($sformatf("if_done c%0d", k), 32'(bus.if_done), 32'(exp_id));
      check_eq($sformatf("busy c%0d", k), 32'(busy), 32'(k <= last));
      if (k == last) begin
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        if (!wr) begin
          if (is_mem) begin
            check_eq("mem_rdata", bus.mem_rdata, exp_rd);
            last_mem_rdata = exp_rd;
          end else begin
            check_eq("if_rdata", bus.if_rdata, exp_rd);
            last_if_rdata = exp_rd;
          end
        end
      end else if (k == last + 1) begin
        check_eq("if_rdata_hold", bus.if_rdata, last_if_rdata);
        check_eq("mem_rdata_hold", bus.mem_rdata, last_mem_rdata);
      end
      // MEM-owned transactions must ignore flush entirely.
      bus.if_flush = (rand_flush && is_mem && k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  int          md_cyc;
  int          id_cyc;
  int          ifa_cyc;
  int          id_cnt;
  logic [31:0] got_rd;
  logic [31:0] old_hi;

  initial begin
    checks         = 0;
    failures       = 0;
    last_if_rdata  = '0;
    last_mem_rdata = '0;
    rst            = 1'b1;
    bd_we          = 1'b0;
    bd_addr        = '0;
    bd_data        = '0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.if_flush   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_len    = '0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    step();
    for (int i = 0; i < 1024; i++) bd_write(i, 8'($urandom));
    bd_write(32'h100, 8'h13);
    bd_write(32'h101, 8'h05);
    bd_write(32'h102, 8'h00);
    bd_write(32'h103, 8'h00);
    bd_write(32'h200, 8'hFE);
    bd_write(32'h201, 8'hFF);

    check_eq("rst ram_a", bus.ram_a, 32'h0);
    check_eq("rst ram_wr", 32'(bus.ram_wr), 32'h0);
    check_eq("rst ram_dout", 32'(bus.ram_dout), 32'h0);
    check_eq("rst if_done", 32'(bus.if_done), 32'h0);
    check_eq("rst mem_done", 32'(bus.mem_done), 32'h0);
    check_eq("rst if_rdata", bus.if_rdata, 32'h0);
    check_eq("rst mem_rdata", bus.mem_rdata, 32'h0);
    check_eq("rst busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();

    run_txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0);
    check_eq("fetch word", last_if_rdata, 32'h0000_0513);
    run_txn(1'b1, 1'b0, 2'b01, 32'h200, 32'h0, 1'b0);
    check_eq("load half", last_mem_rdata, 32'h0000_FFFE);
    run_txn(1'b1, 1'b1, 2'b10, 32'h300, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 1'b0);
    check_eq("store readback", last_mem_rdata, 32'hDEAD_BEEF);

    // Contention: MEM store byte wins, IF fetch follows after DONE.
    ref_mem[32'h10] = 8'h55;
    md_cyc  = -1;
    id_cyc  = -1;
    ifa_cyc = -1;
    id_cnt  = 0;
    step();
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_len   = 2'b00;
    bus.mem_addr  = 32'h10;
    bus.mem_wdata = 32'h0000_0055;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.ram_a == 32'h100 && ifa_cyc < 0) ifa_cyc = k;
      if (bus.mem_done && md_cyc < 0) begin
        md_cyc      = k;
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        id_cnt++;
        if (id_cyc < 0) begin
          id_cyc     = k;
          got_rd     = bus.if_rdata;
          bus.if_req = 1'b0;
        end
      end
    end
    check_eq("cont mem_done cyc", 32'(md_cyc), 32'd2);
    check_eq("cont if start cyc", 32'(ifa_cyc), 32'd4);
    check_eq("cont if_done cyc", 32'(id_cyc), 32'd9);
    check_eq("cont if_done cnt", 32'(id_cnt), 32'd1);
    check_eq("cont if_rdata", got_rd, model_read(32'h100, 4));
    check_eq("cont ram[0x10]", 32'(ram[32'h10]), 32'h55);
    last_if_rdata = got_rd;

    // Flush in cycle 3 of an IF read with a MEM load waiting behind it.
    md_cyc = -1;
    id_cnt = 0;
    got_rd = '0;
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.if_done) id_cnt++;
      if (bus.mem_done && md_cyc < 0) begin
        md_cyc      = k;
        got_rd      = bus.mem_rdata;
        bus.mem_req = 1'b0;
      end
      if (k == 1) begin
        bus.mem_req  = 1'b1;
        bus.mem_wr   = 1'b0;
        bus.mem_len  = 2'b00;
        bus.mem_addr = 32'h200;
      end
      if (k == 3) begin
        check_eq("flush ram_a c3", bus.ram_a, 32'h102);
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
      end
      if (k == 4) begin
        check_eq("flush busy c4", 32'(busy), 32'h0);
        check_eq("flush ram_a c4", bus.ram_a, 32'h0);
        bus.if_flush = 1'b0;
      end
      if (k == 5) check_eq("flush mem start", bus.ram_a, 32'h200);
    end
    check_eq("flush if_done cnt", 32'(id_cnt), 32'd0);
    check_eq("flush mem_done cyc", 32'(md_cyc), 32'd7);
    check_eq("flush mem_rdata", got_rd, 32'h0000_00FE);
    last_mem_rdata = got_rd;
    run_txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0);

    // Reset in cycle 2 of a word store: only bytes 0 and 1 reach RAM.
    old_hi = {16'h0, ref_mem[32'h303], ref_mem[32'h302]};
    step();
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_len   = 2'b10;
    bus.mem_addr  = 32'h300;
    bus.mem_wdata = 32'hA1B2_C3D4;
    step();
    check_eq("rstw ram_wr c1", 32'(bus.ram_wr), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst         = 1'b0;
    bus.mem_req = 1'b0;
    check_eq("rstw ram_wr c3", 32'(bus.ram_wr), 32'h0);
    check_eq("rstw ram_a c3", bus.ram_a, 32'h0);
    check_eq("rstw busy c3", 32'(busy), 32'h0);
    check_eq("rstw if_rdata c3", bus.if_rdata, 32'h0);
    id_cnt = 0;
    for (int k = 4; k <= 8; k++) begin
      step();
      if (bus.mem_done) id_cnt++;
    end
    check_eq("rstw no mem_done", 32'(id_cnt), 32'd0);
    check_eq("rstw hi bytes", {16'h0, ram[32'h303], ram[32'h302]}, old_hi);
    ref_mem[32'h300] = 8'hD4;
    ref_mem[32'h301] = 8'hC3;
    last_if_rdata    = '0;
    last_mem_rdata   = '0;
    run_txn(1'b1, 1'b0, 2'b10, 32'h300, 32'h0, 1'b0);
    check_eq("rstw readback", last_mem_rdata, {old_hi[15:0], 16'hC3D4});

    for (int t = 0; t < 40; t++) begin
      logic        is_mem;
      logic [31:0] a;
      is_mem = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      run_txn(is_mem, is_mem & 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
              $urandom, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
